// File: rtl/mul_operand_stage.sv
// Signed/unsigned operand stage around the combinational multiplier core.
// Stage 1 registers operand magnitudes for the core; stage 2 applies sign correction and selects the result half.
module mul_operand_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [WIDTH-1:0]     core_x,
    output logic [WIDTH-1:0]     core_y,
    input  logic [2*WIDTH-1:0]   core_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [WIDTH-1:0]     out_res,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic               r_s1_valid;
    logic               r_s1_neg;
    logic [1:0]         r_s1_op;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [WIDTH-1:0]   r_core_x;
    logic [WIDTH-1:0]   r_core_y;

    logic               r_s2_valid;
    logic [PW-1:0]      r_out_prod;
    logic [WIDTH-1:0]   r_out_res;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_s1_load;
    logic               w_s2_load;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [PW-1:0]      w_prod;
    logic [WIDTH-1:0]   w_res;

    // Stage 2 frees its slot whenever downstream takes the result, so stage 1 can refill on the same edge.
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);

    // MUL treats both operands as unsigned; the low half does not depend on signedness.
    assign w_sa    = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[WIDTH-1];
    assign w_sb    = (in_op == OP_MULH) && in_b[WIDTH-1];
    assign w_mag_a = w_sa ? WIDTH'(~in_a + WIDTH'(1)) : in_a;
    assign w_mag_b = w_sb ? WIDTH'(~in_b + WIDTH'(1)) : in_b;

    // A zero magnitude with neg set wraps back to zero, so no special case is needed.
    assign w_prod = r_s1_neg ? PW'(~core_p + PW'(1)) : core_p;
    assign w_res  = (r_s1_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];

    // Stage 1: operand capture and magnitude conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_op    <= 2'b00;
            r_s1_tag   <= '0;
            r_core_x   <= '0;
            r_core_y   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_neg   <= w_sa ^ w_sb;
            r_s1_op    <= in_op;
            r_s1_tag   <= in_tag;
            r_core_x   <= w_mag_a;
            r_core_y   <= w_mag_b;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: sign-corrected product held until downstream accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_prod <= '0;
            r_out_res  <= '0;
            r_out_tag  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_out_prod <= w_prod;
            r_out_res  <= w_res;
            r_out_tag  <= r_s1_tag;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign core_x    = r_core_x;
    assign core_y    = r_core_y;
    assign out_valid = r_s2_valid;
    assign out_prod  = r_out_prod;
    assign out_res   = r_out_res;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_mul_operand_stage.sv
// Testbench for mul_operand_stage: directed vector table, corner sequences and random traffic vs a queue model.
module tb_mul_operand_stage;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [1:0]       in_op;
    logic [3:0]       in_tag;
    logic [7:0]       core_x;
    logic [7:0]       core_y;
    logic [15:0]      core_p;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_prod;
    logic [7:0]       out_res;
    logic [3:0]       out_tag;

    mul_operand_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .core_x(core_x), .core_y(core_y), .core_p(core_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_res(out_res), .out_tag(out_tag)
    );

    // Stand-in for the combinational multiplier core.
    assign core_p = 16'(core_x) * 16'(core_y);

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [7:0]  res;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [15:0] prod;
        logic [7:0]  res;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        last_acc;
    logic        got_out;
    logic [15:0] got_prod;
    logic [7:0]  got_res;
    logic [3:0]  got_tag;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_prod;
    logic [7:0]  prev_res;
    logic [3:0]  prev_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: interpret operands per op as signed/unsigned integers and multiply.
    function automatic logic [15:0] ref_prod(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        sa = (op == 2'b01 || op == 2'b10) ? int'($signed(a)) : int'(a);
        sb = (op == 2'b01) ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    // One cycle: drive at negedge, check just before the next rising edge, update the model.
    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input logic ordy);
        exp_t e;
        logic exp_ov;
        logic [15:0] p;
        @(negedge clk);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
        #4;
        got_out = 1'b0;
        exp_ov = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        chk("in_ready", 32'(in_ready), 32'(!(q.size() >= 2 && !ordy)));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (prev_stall) begin
            chk("stall_prod", 32'(out_prod), 32'(prev_prod));
            chk("stall_res", 32'(out_res), 32'(prev_res));
            chk("stall_tag", 32'(out_tag), 32'(prev_tag));
        end
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_prod", 32'(out_prod), 32'(e.prod));
            chk("sb_res", 32'(out_res), 32'(e.res));
            chk("sb_tag", 32'(out_tag), 32'(e.tag));
            got_out = 1'b1; got_prod = out_prod; got_res = out_res; got_tag = out_tag;
        end
        prev_stall = out_valid && !out_ready;
        prev_prod = out_prod; prev_res = out_res; prev_tag = out_tag;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            p = ref_prod(op, a, b);
            e.prod = p;
            e.res  = (op == 2'b00) ? p[7:0] : p[15:8];
            e.tag  = tag;
            e.cyc  = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'b00, 8'h00, 8'h00, 4'h0, ordy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 12) begin
            idle(1'b1);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        idle(1'b1);
    endtask

    vec_t vecs[9];

    initial begin
        int n_out;
        int n_acc;
        int idx;
        int waitn;

        vecs[0] = '{2'b00, 8'h03, 8'h05, 4'h1, 16'h000F, 8'h0F};
        vecs[1] = '{2'b01, 8'hFD, 8'h05, 4'h2, 16'hFFF1, 8'hFF};
        vecs[2] = '{2'b01, 8'h80, 8'h80, 4'h3, 16'h4000, 8'h40};
        vecs[3] = '{2'b11, 8'hFF, 8'hFF, 4'h4, 16'hFE01, 8'hFE};
        vecs[4] = '{2'b10, 8'hFF, 8'hFF, 4'h5, 16'hFF01, 8'hFF};
        vecs[5] = '{2'b00, 8'hFF, 8'hFF, 4'h6, 16'hFE01, 8'h01};
        vecs[6] = '{2'b01, 8'h00, 8'h80, 4'h7, 16'h0000, 8'h00};
        vecs[7] = '{2'b10, 8'h80, 8'hFF, 4'h8, 16'h8080, 8'h80};
        vecs[8] = '{2'b01, 8'h7F, 8'h80, 4'h9, 16'hC080, 8'hC0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_prod", 32'(out_prod), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_core_x", 32'(core_x), 32'd0);
        chk("rst_core_y", 32'(core_y), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: one request at a time, result compared to the table constants.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1);
            chk("vec_accept", 32'(last_acc), 32'd1);
            waitn = 0;
            got_out = 1'b0;
            while (!got_out && waitn < 6) begin
                idle(1'b1);
                waitn++;
            end
            chk("vec_latency", 32'(waitn), 32'd2);
            chk("vec_prod", 32'(got_prod), 32'(vecs[i].prod));
            chk("vec_res", 32'(got_res), 32'(vecs[i].res));
            chk("vec_tag", 32'(got_tag), 32'(vecs[i].tag));
        end
        drain();

        // Back-to-back: 4 requests, 4 consecutive results.
        n_out = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b00, 8'(i + 2), 8'(i + 3), 4'(i), 1'b1);
            chk("b2b_accept", 32'(last_acc), 32'd1);
            if (out_valid) n_out++;
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (out_valid) n_out++;
        end
        chk("b2b_count", 32'(n_out), 32'd4);
        drain();

        // Stall: out_ready low for 5 cycles while 3 requests are offered.
        n_acc = 0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            step(idx < 3, 2'b01, 8'(8'hF0 + idx), 8'h07, 4'(10 + idx), 1'b0);
            if (last_acc) begin n_acc++; idx++; end
        end
        chk("stall_accepted", 32'(n_acc), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        n_out = 0;
        waitn = 0;
        while (idx < 3 && waitn < 6) begin
            step(1'b1, 2'b01, 8'(8'hF0 + idx), 8'h07, 4'(10 + idx), 1'b1);
            if (got_out) n_out++;
            if (last_acc) idx++;
            waitn++;
        end
        chk("stall_third_accept", 32'(idx), 32'd3);
        waitn = 0;
        while (q.size() > 0 && waitn < 8) begin
            idle(1'b1);
            if (got_out) n_out++;
            waitn++;
        end
        chk("stall_results", 32'(n_out), 32'd3);
        drain();

        // Asynchronous reset with both stages full.
        step(1'b1, 2'b11, 8'hAA, 8'h55, 4'hA, 1'b0);
        step(1'b1, 2'b11, 8'h12, 8'h34, 4'hB, 1'b0);
        idle(1'b0);
        chk("pre_rst_full", 32'(q.size()), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_prod", 32'(out_prod), 32'd0);
        chk("arst_core_x", 32'(core_x), 32'd0);
        q.delete();
        prev_stall = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom),
                 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=<200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_operand_stage.md
Name: mul_operand_stage

Overview:
- Two-stage pipelined front/back end around the combinational Wallace multiplier core.
- Accepts multiply requests over a valid/ready handshake and converts signed operands to magnitudes.
- Drives the core's X/Y from registers, captures the core's P, applies sign correction, and presents a full-width product and a selected half downstream.
- Gives the multiplier datapath signed/unsigned support and backpressure-safe throughput of one result per cycle.

Parameters:
- WIDTH, 8: operand width. Must match the core's WIDTH. The core reduces exactly 8 partial products, so 8 is the only supported value.
- TAG_W, 4: width of the opaque request tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_op  input  2  00 MUL (low half), 01 MULH (signed x signed, high), 10 MULHSU (signed a x unsigned b, high), 11 MULHU (unsigned x unsigned, high).
- in_tag  input  TAG_W  request tag.
- core_x  output  WIDTH  magnitude of a, to the core's X.
- core_y  output  WIDTH  magnitude of b, to the core's Y.
- core_p  input  2*WIDTH  unsigned product from the core; combinational function of core_x/core_y.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_prod  output  2*WIDTH  full two's-complement (or unsigned) product per in_op.
- out_res  output  WIDTH  selected half: low half for MUL, high half otherwise.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0, out_valid=0, out_prod=0, out_res=0, out_tag=0, core_x=0, core_y=0. in_ready=1 after reset.
- Handshake: a transfer occurs when valid&&ready on the same edge.
  - Inputs are sampled only on an input transfer.
  - out_* are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Stage 1 (registered on input transfer):
  - sa = in_a[W-1] if op is MULH or MULHSU, else 0. sb = in_b[W-1] if op is MULH, else 0. MUL treats both operands as unsigned; the low half is identical for signed operands.
  - core_x = sa ? -in_a : in_a; core_y = sb ? -in_b : in_b. Arithmetic is modulo 2^W; -(100..0) = 100..0, a correct magnitude when read as unsigned.
  - neg = sa^sb. op and tag are stored.
- Stage 2 (registered on stage-1 advance):
  - out_prod = neg ? (~core_p + 1) : core_p, modulo 2^(2W). out_res = out_prod[W-1:0] if op==00, else out_prod[2W-1:W].
- Advance rules:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational from out_ready; there is no in_valid -> in_ready path.
- Latency and throughput:
  - Latency is 2 cycles: a request accepted at edge N is visible on out_* after edge N+1, with out_valid=1 in cycle N+1..N+2.
  - Throughput is 1 per cycle with out_ready held high.
- Simultaneous events: s1 and s2 both update on one edge when s2 drains and a new request arrives. Data must not be lost or duplicated.
- Full stall (both stages valid, out_ready=0): in_ready=0, all registers hold, core_x/core_y hold.
- Empty: out_valid=0. out_* keep their last values; the bench does not check them.
- Zero operand with a negative sign: the product is 0. neg may be 1; ~0+1 wraps to 0. No special case is required.
- Reset mid-operation: all in-flight requests are discarded, with no output after reset deasserts.

Test Plan:
- MUL a=0x03, b=0x05, tag=1 -> 2 cycles later out_prod=0x000F, out_res=0x0F, out_tag=1.
- MULH a=0xFD (-3), b=0x05 -> out_prod=0xFFF1 (-15), out_res=0xFF. MULH a=0x80, b=0x80 -> out_prod=0x4000, out_res=0x40.
- MULHU a=0xFF, b=0xFF -> out_prod=0xFE01, out_res=0xFE. MULHSU a=0xFF (-1), b=0xFF (255) -> out_prod=0xFF01, out_res=0xFF.
- 4 back-to-back requests, out_ready=1 -> 4 consecutive out_valid cycles with tags in order 0,1,2,3 and in_ready constantly 1.
- out_ready=0 for 5 cycles while 3 requests are offered -> exactly 2 accepted, in_ready=0 with both stages full, outputs stable. Release -> remaining results in order, none lost or duplicated.
- Assert rst_n=0 with both stages full -> out_valid=0 and out_prod=0 immediately (asynchronous). After release: in_ready=1, and no stale result ever appears.
